life_seq_ctrl: RTL and testbench
================================

Name: life_seq_ctrl

Overview:
- Sequencer for the 8x8 Game-of-Life grid.
- Loads seed rows into the grid through a valid/ready port.
- Paces generation steps from a programmable cycle period, and supports free-run, single-step and stop.
- Counts generations; halts on extinction or on reaching a generation limit. Sits between the host/test logic and the grid datapath.

Parameters:
- PERIOD_W, 16, width of the step-period input and internal timer.
- GEN_W, 16, width of the generation counter.
- MAX_GEN, 0, generation limit; 0 means unlimited.
- WDOG_CYCLES, 1024, step_done timeout (only used with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- _rst  in  1  asynchronous, active-low reset.
- cmd_start  in  1  one-cycle pulse: begin free-run.
- cmd_stop  in  1  one-cycle pulse: stop after the current generation.
- cmd_step  in  1  one-cycle pulse: run exactly one generation.
- period  in  PERIOD_W  cycles between steps; sampled on accepted cmd_start.
- seed_valid  in  1  seed row offered.
- seed_ready  out  1  seed row accepted when valid&&ready.
- seed_row  in  3  row index 0..7.
- seed_data  in  8  row bits, bit 0 = column 0.
- load_en  out  1  one-cycle grid row write strobe.
- load_row  out  3  registered row index.
- load_data  out  8  registered row data.
- step  out  1  one-cycle pulse: grid computes next generation.
- step_done  in  1  grid finished the generation.
- grid_empty  in  1  no live cells; valid in the step_done cycle.
- gen_count  out  GEN_W  completed generations.
- running  out  1  free-run active.
- halted  out  1  terminal condition reached.
- wdog_err  out  1  step_done timeout.

Behaviour:
- Reset (async, _rst=0): state IDLE. step=0, load_en=0, load_row=0, load_data=0, gen_count=0, running=0, halted=0, wdog_err=0, stop_pending=0, single=0.
- States: IDLE, RUN_WAIT, STEP, HALT.
- seed_ready is combinational: (IDLE or HALT) && !cmd_start && !cmd_step. It is therefore 1 during reset.
- Seed transfer: seed_valid&&seed_ready at edge N gives load_en=1 with the row/data for the cycle after edge N, then 0.
  - Back-to-back transfers are allowed, one per cycle.
  - Each transfer clears gen_count and halted.
  - A transfer in HALT moves to IDLE.
- IDLE command priority: cmd_stop > cmd_start > cmd_step. cmd_stop in IDLE is a no-op.
- cmd_start (IDLE): period_q = max(period,1); timer = period_q-1; running=1; go to RUN_WAIT.
- RUN_WAIT:
  - The timer decrements each cycle. At timer==0, go to STEP and assert step for exactly one cycle.
  - cmd_stop goes to IDLE next cycle with running=0; no step is issued.
- cmd_step (IDLE): single=1; go to STEP and pulse step next cycle. running stays 0.
- STEP:
  - step_done is ignored in the cycle step is high.
  - Waiting for step_done has no time limit (unless the optional feature is enabled).
  - cmd_stop here sets stop_pending.
- On step_done:
  - gen_count+1, saturating at all-ones.
  - Then evaluate in order:
    1. grid_empty, or (MAX_GEN!=0 and the new count==MAX_GEN): go to HALT, halted=1, running=0.
    2. single or stop_pending: go to IDLE, running=0, clear both flags.
    3. Otherwise go to RUN_WAIT and reload timer = period_q-1.
- period=1 gives step once every (1 + step_done latency + 1) cycles; the timer never underflows.
- HALT:
  - All outputs hold.
  - cmd_start and cmd_step are ignored.
  - cmd_stop goes to IDLE and clears halted; gen_count is kept.
- Simultaneous cmd_stop and step_done in STEP: the stop is honoured in that same evaluation (rule 2), unless rule 1 applies.
- _rst assertion mid-step: immediate return to the reset values. A late step_done after reset is ignored (the block is in IDLE).

Optional Feature:
- Macro LIFE_SEQ_WDOG_EN.
- Defined:
  - A counter runs in STEP from the cycle after step.
  - If WDOG_CYCLES cycles pass without step_done: go to HALT, wdog_err=1, halted=1, running=0, gen_count unchanged.
  - wdog_err clears only on a seed transfer or cmd_stop.
- Undefined: no counter logic; wdog_err is tied 0; STEP waits indefinitely.

Test Plan:
- Reset then seed rows 0..7 with data 8'h00..8'h07 back-to-back → load_en high 8 consecutive cycles, load_row/load_data matching each row with 1-cycle latency, seed_ready=1 throughout.
- period=4, cmd_start, step_done returned 2 cycles after each step, grid_empty=0 → step pulses 7 cycles apart; gen_count=3 after the third step_done; running=1.
- cmd_step in IDLE → exactly one step pulse; after step_done, gen_count=1, running=0, state IDLE, no further step.
- MAX_GEN=5, free-run → halted=1 when gen_count=5. cmd_start then ignored (no step); cmd_stop clears halted; gen_count stays 5.
- cmd_stop in the same cycle step is high → one more step_done accepted; gen_count+1, then IDLE. Separately, grid_empty=1 with step_done → HALT.
- With LIFE_SEQ_WDOG_EN and WDOG_CYCLES=16, step_done withheld → wdog_err=1 and halted=1 exactly 16 cycles after the step pulse. Without the macro, wdog_err stays 0 and the block stays in STEP.

Source files
------------

// File: rtl/life_seq_ctrl.sv
// life_seq_ctrl: seed-row loader and generation sequencer for the 8x8 Game-of-Life grid.
// Define LIFE_SEQ_WDOG_EN to build in the step_done watchdog (wdog_err); otherwise wdog_err is tied low.
module life_seq_ctrl #(
  parameter int PERIOD_W    = 16,
  parameter int GEN_W       = 16,
  parameter int MAX_GEN     = 0,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                _rst,
  input  logic                cmd_start,
  input  logic                cmd_stop,
  input  logic                cmd_step,
  input  logic [PERIOD_W-1:0] period,
  input  logic                seed_valid,
  output logic                seed_ready,
  input  logic [2:0]          seed_row,
  input  logic [7:0]          seed_data,
  output logic                load_en,
  output logic [2:0]          load_row,
  output logic [7:0]          load_data,
  output logic                step,
  input  logic                step_done,
  input  logic                grid_empty,
  output logic [GEN_W-1:0]    gen_count,
  output logic                running,
  output logic                halted,
  output logic                wdog_err
);

  typedef enum logic [1:0] {IDLE, RUN_WAIT, STEP, HALT} state_t;

  state_t              state, state_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] timer, timer_d;
  logic [GEN_W-1:0]    gen_d, gen_inc;
  logic                running_d, halted_d;
  logic                stop_pending, stop_pending_d;
  logic                single, single_d;
  logic                step_d, load_en_d;
  logic [2:0]          load_row_d;
  logic [7:0]          load_data_d;
  logic                seed_xfer, done_ok, hit_limit, wdog_trip;

  function automatic logic [GEN_W-1:0] sat_inc(input logic [GEN_W-1:0] v);
    return (&v) ? v : v + GEN_W'(1);
  endfunction

  assign seed_ready = ((state == IDLE) || (state == HALT)) && !cmd_start && !cmd_step;
  assign seed_xfer  = seed_valid && seed_ready;
  // A step_done coinciding with our own step pulse belongs to an earlier request.
  assign done_ok    = step_done && !step;
  assign gen_inc    = sat_inc(gen_count);
  assign hit_limit  = (MAX_GEN != 0) && (gen_inc == GEN_W'(MAX_GEN));

`ifdef LIFE_SEQ_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_cnt, wdog_cnt_d;
  logic              wdog_err_q, wdog_err_d;

  // Counter is zero in the step cycle, so the trip lands WDOG_CYCLES cycles after step.
  assign wdog_trip = (state == STEP) && !done_ok && (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));
  assign wdog_err  = wdog_err_q;

  always_comb begin
    wdog_cnt_d = (state == STEP) ? wdog_cnt + WDOG_W'(1) : '0;
    wdog_err_d = wdog_err_q;
    if (seed_xfer || cmd_stop) wdog_err_d = 1'b0;
    if (wdog_trip)             wdog_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      wdog_cnt   <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_cnt   <= wdog_cnt_d;
      wdog_err_q <= wdog_err_d;
    end
  end
`else
  assign wdog_trip = 1'b0;
  assign wdog_err  = (WDOG_CYCLES < 0);
`endif

  always_comb begin
    state_d        = state;
    period_d       = period_q;
    timer_d        = timer;
    gen_d          = gen_count;
    running_d      = running;
    halted_d       = halted;
    stop_pending_d = stop_pending;
    single_d       = single;
    step_d         = 1'b0;
    load_en_d      = 1'b0;
    load_row_d     = load_row;
    load_data_d    = load_data;

    if (seed_xfer) begin
      load_en_d   = 1'b1;
      load_row_d  = seed_row;
      load_data_d = seed_data;
      gen_d       = '0;
      halted_d    = 1'b0;
    end

    unique case (state)
      IDLE: begin
        if (cmd_stop) begin
          state_d = IDLE;
        end else if (cmd_start) begin
          period_d  = (period == '0) ? PERIOD_W'(1) : period;
          timer_d   = (period == '0) ? '0 : period - PERIOD_W'(1);
          running_d = 1'b1;
          state_d   = RUN_WAIT;
        end else if (cmd_step) begin
          single_d = 1'b1;
          step_d   = 1'b1;
          state_d  = STEP;
        end
      end
      RUN_WAIT: begin
        if (cmd_stop) begin
          running_d = 1'b0;
          state_d   = IDLE;
        end else if (timer == '0) begin
          step_d  = 1'b1;
          state_d = STEP;
        end else begin
          timer_d = timer - PERIOD_W'(1);
        end
      end
      STEP: begin
        if (cmd_stop) stop_pending_d = 1'b1;
        if (done_ok) begin
          gen_d = gen_inc;
          if (grid_empty || hit_limit) begin
            halted_d       = 1'b1;
            running_d      = 1'b0;
            single_d       = 1'b0;
            stop_pending_d = 1'b0;
            state_d        = HALT;
          end else if (single || stop_pending || cmd_stop) begin
            running_d      = 1'b0;
            single_d       = 1'b0;
            stop_pending_d = 1'b0;
            state_d        = IDLE;
          end else begin
            timer_d = period_q - PERIOD_W'(1);
            state_d = RUN_WAIT;
          end
        end else if (wdog_trip) begin
          halted_d       = 1'b1;
          running_d      = 1'b0;
          single_d       = 1'b0;
          stop_pending_d = 1'b0;
          state_d        = HALT;
        end
      end
      HALT: begin
        // Start/step are ignored here; only stop or a new seed leaves.
        if (cmd_stop || seed_xfer) begin
          halted_d = 1'b0;
          state_d  = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state        <= IDLE;
      period_q     <= '0;
      timer        <= '0;
      gen_count    <= '0;
      running      <= 1'b0;
      halted       <= 1'b0;
      stop_pending <= 1'b0;
      single       <= 1'b0;
      step         <= 1'b0;
      load_en      <= 1'b0;
      load_row     <= '0;
      load_data    <= '0;
    end else begin
      state        <= state_d;
      period_q     <= period_d;
      timer        <= timer_d;
      gen_count    <= gen_d;
      running      <= running_d;
      halted       <= halted_d;
      stop_pending <= stop_pending_d;
      single       <= single_d;
      step         <= step_d;
      load_en      <= load_en_d;
      load_row     <= load_row_d;
      load_data    <= load_data_d;
    end
  end

endmodule

// File: tb/tb_life_seq_ctrl.sv
// Bench for life_seq_ctrl: random periods/latencies against step-time arithmetic from the sequencing rules.
// Honours LIFE_SEQ_WDOG_EN to pick the expected watchdog behaviour.
module tb_life_seq_ctrl;

  logic        clk = 1'b0;
  logic        _rst;
  logic        cmd_start, cmd_stop, cmd_step;
  logic [15:0] period;
  logic        seed_valid;
  logic        seed_ready;
  logic [2:0]  seed_row;
  logic [7:0]  seed_data;
  logic        load_en;
  logic [2:0]  load_row;
  logic [7:0]  load_data;
  logic        step;
  logic        step_done, grid_empty;
  logic [15:0] gen_count;
  logic        running, halted, wdog_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int step_log[$];
  int done_due[$];
  bit resp_en = 1'b0;
  int lat = 1;
  bit empty_val = 1'b0;

  always #5 clk = ~clk;

  life_seq_ctrl #(.PERIOD_W(16), .GEN_W(16), .MAX_GEN(5), .WDOG_CYCLES(16)) dut (
    .clk(clk), ._rst(_rst),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_step(cmd_step), .period(period),
    .seed_valid(seed_valid), .seed_ready(seed_ready), .seed_row(seed_row), .seed_data(seed_data),
    .load_en(load_en), .load_row(load_row), .load_data(load_data),
    .step(step), .step_done(step_done), .grid_empty(grid_empty),
    .gen_count(gen_count), .running(running), .halted(halted), .wdog_err(wdog_err)
  );

  // Advance one cycle; log step pulses and play the grid's step_done response.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    cmd_start  = 1'b0;
    cmd_stop   = 1'b0;
    cmd_step   = 1'b0;
    seed_valid = 1'b0;
    if (step === 1'b1) begin
      step_log.push_back(cyc);
      if (resp_en) done_due.push_back(cyc + lat);
    end
    step_done = 1'b0;
    if (done_due.size() > 0 && done_due[0] == cyc) begin
      step_done = 1'b1;
      void'(done_due.pop_front());
    end
    grid_empty = step_done ? empty_val : 1'($urandom);
  endtask

  task automatic seed_one();
    tick();
    seed_valid = 1'b1;
    seed_row   = 3'($urandom);
    seed_data  = 8'($urandom_range(1, 255));
    tick();
    step_log.delete();
    done_due.delete();
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if ({step, load_en, load_row, load_data, gen_count, running, halted, wdog_err} !== '0)
      begin errors++; $display("FAIL reset outputs: got %h required 0",
        {step, load_en, load_row, load_data, gen_count, running, halted, wdog_err}); end
    checks++;
    if (seed_ready !== 1'b1) begin errors++; $display("FAIL reset seed_ready: got %b required 1", seed_ready); end
    _rst = 1'b1;
    tick();
  endtask

  task automatic test_seed();
    logic [2:0] rows[8];
    logic [7:0] dat[8];
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 8; i++) begin
        rows[i] = (pass == 0) ? 3'(i) : 3'($urandom);
        dat[i]  = (pass == 0) ? 8'(i) : 8'($urandom);
      end
      tick();
      for (int i = 0; i <= 8; i++) begin
        if (i > 0) begin
          checks++;
          if ({load_en, load_row, load_data} !== {1'b1, rows[i-1], dat[i-1]})
            begin errors++; $display("FAIL seed load[%0d]: got en=%b row=%0d data=%h required en=1 row=%0d data=%h",
              i-1, load_en, load_row, load_data, rows[i-1], dat[i-1]); end
        end
        if (i < 8) begin
          seed_valid = 1'b1;
          seed_row   = rows[i];
          seed_data  = dat[i];
          #1;
          checks++;
          if (seed_ready !== 1'b1) begin errors++; $display("FAIL seed_ready[%0d]: got %b required 1", i, seed_ready); end
        end
        tick();
      end
      checks++;
      if (load_en !== 1'b0) begin errors++; $display("FAIL seed load_en after burst: got %b required 0", load_en); end
      checks++;
      if (gen_count !== 16'd0) begin errors++; $display("FAIL seed gen_count: got %0d required 0", gen_count); end
    end
  endtask

  task automatic test_free_run();
    int p_in, pe, l, c, target, exp_s;
    for (int it = 0; it < 3; it++) begin
      p_in = (it == 0) ? 4 : (it == 1) ? int'($urandom_range(1, 6)) : 0;
      pe   = (p_in == 0) ? 1 : p_in;
      l    = (it == 0) ? 2 : int'($urandom_range(1, 4));
      seed_one();
      resp_en = 1'b1; lat = l; empty_val = 1'b0;
      period = 16'(p_in);
      cmd_start = 1'b1;
      c = cyc;
      #1;
      checks++;
      if (seed_ready !== 1'b0) begin errors++; $display("FAIL free_run seed_ready with cmd_start: got %b required 0", seed_ready); end
      tick();
      period = 16'($urandom);
      target = c + pe + 1 + 2 * (l + 1 + pe) + l + 1;
      while (cyc < target) tick();
      checks++;
      if (step_log.size() !== 3) begin errors++; $display("FAIL free_run step count: got %0d required 3", step_log.size()); end
      if (step_log.size() == 3) begin
        for (int k = 0; k < 3; k++) begin
          exp_s = c + pe + 1 + k * (l + 1 + pe);
          checks++;
          if (step_log[k] !== exp_s) begin errors++; $display("FAIL free_run step[%0d] cycle: got %0d required %0d", k, step_log[k], exp_s); end
        end
      end
      checks++;
      if (gen_count !== 16'd3) begin errors++; $display("FAIL free_run gen_count: got %0d required 3", gen_count); end
      checks++;
      if (running !== 1'b1) begin errors++; $display("FAIL free_run running: got %b required 1", running); end
      cmd_stop = 1'b1;
      tick();
      checks++;
      if (running !== 1'b0) begin errors++; $display("FAIL free_run running after stop: got %b required 0", running); end
      repeat (12) tick();
      checks++;
      if (step_log.size() !== 3) begin errors++; $display("FAIL free_run steps after stop: got %0d required 3", step_log.size()); end
    end
  endtask

  task automatic test_single_step();
    int l, c;
    for (int it = 0; it < 2; it++) begin
      l = int'($urandom_range(1, 5));
      seed_one();
      resp_en = 1'b1; lat = l; empty_val = 1'b0;
      cmd_step = 1'b1;
      c = cyc;
      #1;
      checks++;
      if (seed_ready !== 1'b0) begin errors++; $display("FAIL single seed_ready with cmd_step: got %b required 0", seed_ready); end
      tick();
      checks++;
      if ({step, running} !== 2'b10) begin errors++; $display("FAIL single step/running: got %b required 10", {step, running}); end
      step_done = 1'b1;
      grid_empty = 1'b0;
      tick();
      checks++;
      if (gen_count !== 16'd0) begin errors++; $display("FAIL single done during step counted: got %0d required 0", gen_count); end
      while (cyc < c + l + 2) tick();
      checks++;
      if (gen_count !== 16'd1) begin errors++; $display("FAIL single gen_count: got %0d required 1", gen_count); end
      repeat (10) tick();
      checks++;
      if (step_log.size() !== 1 || step_log[0] !== c + 1)
        begin errors++; $display("FAIL single step log: got %0d pulses (first at %0d) required 1 at %0d",
          step_log.size(), (step_log.size() > 0) ? step_log[0] : -1, c + 1); end
      #1;
      checks++;
      if ({seed_ready, running, halted} !== 3'b100) begin errors++; $display("FAIL single idle state: got %b required 100", {seed_ready, running, halted}); end
    end
  endtask

  task automatic test_max_gen();
    int pe, l, c, halt_at;
    pe = int'($urandom_range(1, 4));
    l  = int'($urandom_range(1, 3));
    seed_one();
    resp_en = 1'b1; lat = l; empty_val = 1'b0;
    period = 16'(pe);
    cmd_start = 1'b1;
    c = cyc;
    tick();
    halt_at = c + pe + 1 + 4 * (l + 1 + pe) + l + 1;
    while (cyc < halt_at - 1) tick();
    checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL max_gen early halt: got %b required 0", halted); end
    tick();
    checks++;
    if ({halted, running, gen_count} !== {2'b10, 16'd5}) begin errors++; $display("FAIL max_gen halt: got halted=%b running=%b gen=%0d required 1 0 5", halted, running, gen_count); end
    cmd_start = 1'b1;
    #1;
    checks++;
    if (seed_ready !== 1'b0) begin errors++; $display("FAIL max_gen seed_ready with cmd_start: got %b required 0", seed_ready); end
    tick();
    repeat (4) tick();
    cmd_step = 1'b1;
    repeat (10) tick();
    checks++;
    if (step_log.size() !== 5) begin errors++; $display("FAIL max_gen steps in halt: got %0d required 5", step_log.size()); end
    checks++;
    if (halted !== 1'b1) begin errors++; $display("FAIL max_gen halt held: got %b required 1", halted); end
    cmd_stop = 1'b1;
    tick();
    checks++;
    if ({halted, gen_count} !== {1'b0, 16'd5}) begin errors++; $display("FAIL max_gen stop: got halted=%b gen=%0d required 0 5", halted, gen_count); end
  endtask

  task automatic test_stop_during_step();
    int pe, l, o, c, s;
    for (int it = 0; it < 3; it++) begin
      pe = int'($urandom_range(1, 4));
      l  = int'($urandom_range(1, 4));
      o  = (it == 0) ? 0 : (it == 1) ? l : int'($urandom_range(0, l));
      seed_one();
      resp_en = 1'b1; lat = l; empty_val = 1'b0;
      period = 16'(pe);
      cmd_start = 1'b1;
      c = cyc;
      s = c + pe + 1;
      tick();
      while (cyc < s + o) tick();
      cmd_stop = 1'b1;
      while (cyc < s + l + 1) tick();
      checks++;
      if ({gen_count, running} !== {16'd1, 1'b0}) begin errors++; $display("FAIL stop_in_step[%0d]: got gen=%0d running=%b required 1 0", o, gen_count, running); end
      repeat (10) tick();
      checks++;
      if (step_log.size() !== 1 || halted !== 1'b0) begin errors++; $display("FAIL stop_in_step[%0d] idle: got %0d steps halted=%b required 1 0", o, step_log.size(), halted); end
    end
  endtask

  task automatic test_empty_halt();
    int pe, l, c;
    for (int it = 0; it < 2; it++) begin
      pe = int'($urandom_range(1, 4));
      l  = int'($urandom_range(1, 4));
      seed_one();
      resp_en = 1'b1; lat = l; empty_val = 1'b1;
      period = 16'(pe);
      cmd_start = 1'b1;
      c = cyc;
      tick();
      while (cyc < c + pe + 1 + l + 1) tick();
      checks++;
      if ({halted, running, gen_count} !== {2'b10, 16'd1}) begin errors++; $display("FAIL empty halt: got halted=%b running=%b gen=%0d required 1 0 1", halted, running, gen_count); end
      repeat (10) tick();
      checks++;
      if (step_log.size() !== 1) begin errors++; $display("FAIL empty halt steps: got %0d required 1", step_log.size()); end
      if (it == 0) begin
        cmd_stop = 1'b1;
        tick();
        checks++;
        if ({halted, gen_count} !== {1'b0, 16'd1}) begin errors++; $display("FAIL empty stop exit: got halted=%b gen=%0d required 0 1", halted, gen_count); end
      end else begin
        seed_valid = 1'b1; seed_row = 3'd5; seed_data = 8'hA5;
        tick();
        checks++;
        if ({halted, gen_count, load_en, load_data} !== {1'b0, 16'd0, 1'b1, 8'hA5}) begin errors++; $display("FAIL empty seed exit: got halted=%b gen=%0d en=%b data=%h required 0 0 1 a5", halted, gen_count, load_en, load_data); end
      end
      empty_val = 1'b0;
    end
  endtask

  task automatic test_reset_mid_step();
    seed_one();
    resp_en = 1'b1; lat = 4; empty_val = 1'b0;
    cmd_step = 1'b1;
    tick();
    tick();
    #2;
    _rst = 1'b0;
    #1;
    checks++;
    if ({step, running, halted, load_en, load_row, load_data, gen_count} !== '0)
      begin errors++; $display("FAIL mid reset outputs: got %h required 0", {step, running, halted, load_en, load_row, load_data, gen_count}); end
    checks++;
    if (seed_ready !== 1'b1) begin errors++; $display("FAIL mid reset seed_ready: got %b required 1", seed_ready); end
    tick();
    _rst = 1'b1;
    repeat (10) tick();
    checks++;
    if (gen_count !== 16'd0 || step_log.size() !== 1) begin errors++; $display("FAIL late step_done: got gen=%0d steps=%0d required 0 1", gen_count, step_log.size()); end
  endtask

  task automatic test_wdog();
    int s;
    seed_one();
    resp_en = 1'b0;
    cmd_step = 1'b1;
    s = cyc + 1;
`ifdef LIFE_SEQ_WDOG_EN
    while (cyc < s + 15) tick();
    checks++;
    if ({wdog_err, halted} !== 2'b00) begin errors++; $display("FAIL wdog early: got %b required 00", {wdog_err, halted}); end
    tick();
    checks++;
    if ({wdog_err, halted, running, gen_count} !== {3'b110, 16'd0}) begin errors++; $display("FAIL wdog trip: got err=%b halted=%b running=%b gen=%0d required 1 1 0 0", wdog_err, halted, running, gen_count); end
    cmd_stop = 1'b1;
    tick();
    checks++;
    if ({wdog_err, halted} !== 2'b00) begin errors++; $display("FAIL wdog clear: got %b required 00", {wdog_err, halted}); end
`else
    while (cyc < s + 40) tick();
    #1;
    checks++;
    if ({wdog_err, halted, seed_ready} !== 3'b000) begin errors++; $display("FAIL no-wdog wait: got err/halted/ready=%b required 000", {wdog_err, halted, seed_ready}); end
    step_done = 1'b1;
    grid_empty = 1'b0;
    tick();
    #1;
    checks++;
    if ({gen_count, seed_ready} !== {16'd1, 1'b1}) begin errors++; $display("FAIL no-wdog late done: got gen=%0d ready=%b required 1 1", gen_count, seed_ready); end
`endif
  endtask

  initial begin
    _rst = 1'b0;
    cmd_start = 1'b0; cmd_stop = 1'b0; cmd_step = 1'b0;
    period = '0; seed_valid = 1'b0; seed_row = '0; seed_data = '0;
    step_done = 1'b0; grid_empty = 1'b0;
    test_reset();
    test_seed();
    test_free_run();
    test_single_step();
    test_max_gen();
    test_stop_during_step();
    test_empty_halt();
    test_reset_mid_step();
    test_wdog();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete (checks=%0d)", checks);
    $fatal(1, "timeout");
  end

endmodule
